// File: rtl/bram_sp_ctrl_pkg.sv
// Shared types and defaults for the single-port BRAM initiator.
package bram_sp_ctrl_pkg;

  // Default geometry, matching the BRAM the controller normally drives
  localparam int unsigned DEF_WIDTH = 36;
  localparam int unsigned DEF_DEPTH = 1024;

  // Controller modes: serve the client, or fill the whole array
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

endpackage

// File: rtl/bram_sp_ctrl_if.sv
// Client-side request/response channels of the BRAM initiator.
interface bram_sp_ctrl_if #(
  parameter int unsigned WIDTH = 36,
  parameter int unsigned AW    = 10
);

  logic             req_valid;
  logic             req_ready;
  logic             req_rw;
  logic [AW-1:0]    req_addr;
  logic [WIDTH-1:0] req_data;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_data;

  // Client side
  modport master (
    output req_valid, req_rw, req_addr, req_data, rsp_ready,
    input  req_ready, rsp_valid, rsp_data
  );

  // Controller side
  modport slave (
    input  req_valid, req_rw, req_addr, req_data, rsp_ready,
    output req_ready, rsp_valid, rsp_data
  );

endinterface

// File: rtl/bram_sp_ctrl.sv
// Initiator for a pseudo single-ported BRAM with a 1-cycle registered read.
// Serves one client over valid/ready request and response channels and
// offers a bulk CLEAR that writes CLEAR_VALUE to every address.
module bram_sp_ctrl
  import bram_sp_ctrl_pkg::*;
#(
  parameter int unsigned      WIDTH       = DEF_WIDTH,
  parameter int unsigned      DEPTH       = DEF_DEPTH,
  parameter logic [WIDTH-1:0] CLEAR_VALUE = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  bram_sp_ctrl_if.slave            bus,
  input  logic                     i_clear_start,
  output logic                     o_clear_busy,
  output logic                     o_clear_done,
  output logic                     o_mem_en,
  output logic                     o_mem_rw,
  output logic [$clog2(DEPTH)-1:0] o_mem_addr,
  output logic [WIDTH-1:0]         o_mem_data_in,
  input  logic [WIDTH-1:0]         i_mem_data_out
);

  localparam int unsigned   AW        = $clog2(DEPTH);
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [AW-1:0] r_cnt;
  logic [AW-1:0] w_cnt_nxt;
  logic          r_rsp_valid;
  logic          w_rsp_valid_nxt;
  logic          r_clear_done;
  logic          w_clear_done_nxt;
  logic          w_rsp_stall;
  logic          w_req_ready;
  logic          w_accept;

  // A response the client has not taken blocks new requests, so the BRAM
  // output register is never overwritten before it is consumed
  always_comb begin
    w_rsp_stall = r_rsp_valid && !bus.rsp_ready;
    w_req_ready = (r_state == IDLE) && !w_rsp_stall;
    w_accept    = bus.req_valid && w_req_ready && !rst;
  end

  // State, clear counter, response flag and done pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_rsp_valid  <= 1'b0;
      r_clear_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_rsp_valid  <= w_rsp_valid_nxt;
      r_clear_done <= w_clear_done_nxt;
    end
  end

  // Next state and BRAM port drive; an accepted request reaches the BRAM in
  // the same cycle, a clear_start alongside it takes effect one cycle later
  always_comb begin
    w_state_nxt      = r_state;
    w_cnt_nxt        = r_cnt;
    w_clear_done_nxt = 1'b0;
    o_mem_en         = 1'b0;
    o_mem_rw         = 1'b0;
    o_mem_addr       = '0;
    o_mem_data_in    = '0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          o_mem_en      = 1'b1;
          o_mem_rw      = bus.req_rw;
          o_mem_addr    = bus.req_addr;
          o_mem_data_in = bus.req_data;
        end
        if (i_clear_start) begin
          w_state_nxt = CLEAR;
          w_cnt_nxt   = '0;
        end
      end
      CLEAR: begin
        o_mem_en      = 1'b1;
        o_mem_rw      = 1'b1;
        o_mem_addr    = r_cnt;
        o_mem_data_in = CLEAR_VALUE;
        // Terminal compare rather than wrap, so non-power-of-2 depths stop
        // at the last real word
        if (r_cnt == LAST_ADDR) begin
          w_state_nxt      = IDLE;
          w_cnt_nxt        = '0;
          w_clear_done_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + AW'(1);
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Response flag: set by an accepted read, dropped on handshake unless a
  // new read is accepted in the same cycle
  always_comb begin
    w_rsp_valid_nxt = r_rsp_valid;
    if (w_accept && !bus.req_rw) begin
      w_rsp_valid_nxt = 1'b1;
    end else if (r_rsp_valid && bus.rsp_ready) begin
      w_rsp_valid_nxt = 1'b0;
    end
  end

  assign bus.req_ready = w_req_ready;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_data  = i_mem_data_out;
  assign o_clear_busy  = (r_state == CLEAR);
  assign o_clear_done  = r_clear_done;

endmodule
